bram_arbiter: RTL and testbench

- Shares one `bram` instance (256x16, separate write and read ports, 1-cycle registered read) between two requesters, A and B.
- Each BRAM port is arbitrated independently, round-robin on contention, so one write and one read can issue in the same cycle.
- A same-cycle read/write to the same address is resolved by forwarding, so a read always returns the newest data.
- Grants are held off for a start-up settle period after reset.

---
 rtl/bram_arbiter.sv | 150 +++++++++++++++
 tb/tb_bram_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one simple-dual-port BRAM between requesters A and B.
// The write port and the read port are arbitrated independently (round-robin
// on contention). A read that collides with a same-cycle write to the same
// address returns the freshly written data through a one-entry bypass.
// Grants are held off for INIT_WAIT cycles after reset release.
module bram_arbiter #(
  parameter int ADDR_SZ   = 8,
  parameter int DATA_SZ   = 16,
  parameter int INIT_WAIT = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_a_valid,
  output logic               o_a_ready,
  input  logic               i_a_wr,
  input  logic [ADDR_SZ-1:0] i_a_addr,
  input  logic [DATA_SZ-1:0] i_a_wdata,
  output logic               o_a_rsp,
  output logic [DATA_SZ-1:0] o_a_rdata,
  input  logic               i_b_valid,
  output logic               o_b_ready,
  input  logic               i_b_wr,
  input  logic [ADDR_SZ-1:0] i_b_addr,
  input  logic [DATA_SZ-1:0] i_b_wdata,
  output logic               o_b_rsp,
  output logic [DATA_SZ-1:0] o_b_rdata,
  output logic               o_wr_en,
  output logic [ADDR_SZ-1:0] o_waddr,
  output logic [DATA_SZ-1:0] o_wdata,
  output logic               o_rd_en,
  output logic [ADDR_SZ-1:0] o_raddr,
  input  logic [DATA_SZ-1:0] i_rdata
);

  localparam int CNT_W = (INIT_WAIT > 0) ? $clog2(INIT_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_V = CNT_W'(INIT_WAIT);

  // Pointer encoding: 0 = A was granted last, 1 = B was granted last.
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wptr;
  logic               r_rptr;
  logic               r_a_rsp;
  logic               r_b_rsp;
  logic               r_byp;
  logic [DATA_SZ-1:0] r_byp_data;

  logic               w_live;
  logic               w_a_wc;
  logic               w_b_wc;
  logic               w_a_rc;
  logic               w_b_rc;
  logic               w_a_wg;
  logic               w_b_wg;
  logic               w_a_rg;
  logic               w_b_rg;
  logic               w_byp_hit;
  logic [DATA_SZ-1:0] w_rsp_data;

  // Arbitration is live only out of reset and once the settle count is reached.
  assign w_live = i_rst_n && (r_cnt == WAIT_V);

  // Settle counter: counts up after reset release and saturates at INIT_WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt != WAIT_V) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Candidate detection and round-robin grants for each BRAM port.
  always_comb begin
    w_a_wc = w_live && i_a_valid && i_a_wr;
    w_b_wc = w_live && i_b_valid && i_b_wr;
    w_a_rc = w_live && i_a_valid && !i_a_wr;
    w_b_rc = w_live && i_b_valid && !i_b_wr;
    w_a_wg = w_a_wc && (!w_b_wc || r_wptr);
    w_b_wg = w_b_wc && (!w_a_wc || !r_wptr);
    w_a_rg = w_a_rc && (!w_b_rc || r_rptr);
    w_b_rg = w_b_rc && (!w_a_rc || !r_rptr);
  end

  // BRAM port drive: the winner's request passes straight through, else zero.
  always_comb begin
    o_wr_en = w_a_wg || w_b_wg;
    o_waddr = '0;
    o_wdata = '0;
    o_rd_en = w_a_rg || w_b_rg;
    o_raddr = '0;
    if (w_a_wg) begin
      o_waddr = i_a_addr;
      o_wdata = i_a_wdata;
    end else if (w_b_wg) begin
      o_waddr = i_b_addr;
      o_wdata = i_b_wdata;
    end
    if (w_a_rg) begin
      o_raddr = i_a_addr;
    end else if (w_b_rg) begin
      o_raddr = i_b_addr;
    end
  end

  assign o_a_ready = w_a_wg || w_a_rg;
  assign o_b_ready = w_b_wg || w_b_rg;

  // Same-address read/write in one cycle: the BRAM returns stale data, so bypass.
  assign w_byp_hit = o_wr_en && o_rd_en && (o_raddr == o_waddr);

  // Round-robin pointers record the most recent winner of each port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= 1'b1;
      r_rptr <= 1'b1;
    end else begin
      if (w_a_wg) begin
        r_wptr <= 1'b0;
      end else if (w_b_wg) begin
        r_wptr <= 1'b1;
      end
      if (w_a_rg) begin
        r_rptr <= 1'b0;
      end else if (w_b_rg) begin
        r_rptr <= 1'b1;
      end
    end
  end

  // Response valids and bypass capture, aligned with the BRAM's read latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_rsp    <= 1'b0;
      r_b_rsp    <= 1'b0;
      r_byp      <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_a_rsp    <= w_a_rg;
      r_b_rsp    <= w_b_rg;
      r_byp      <= w_byp_hit;
      r_byp_data <= w_byp_hit ? o_wdata : '0;
    end
  end

  assign w_rsp_data = r_byp ? r_byp_data : i_rdata;
  assign o_a_rsp    = r_a_rsp;
  assign o_b_rsp    = r_b_rsp;
  assign o_a_rdata  = r_a_rsp ? w_rsp_data : '0;
  assign o_b_rdata  = r_b_rsp ? w_rsp_data : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed testbench for bram_arbiter with a behavioural 256x16 BRAM attached.
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready, a_wr, a_rsp;
  logic [7:0]  a_addr;
  logic [15:0] a_wdata, a_rdata;
  logic        b_valid, b_ready, b_wr, b_rsp;
  logic [7:0]  b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic        wr_en, rd_en;
  logic [7:0]  waddr, raddr;
  logic [15:0] wdata, rdata_q;
  logic [15:0] mem [256];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bram_arbiter #(.ADDR_SZ(8), .DATA_SZ(16), .INIT_WAIT(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_wr(a_wr), .i_a_addr(a_addr),
    .i_a_wdata(a_wdata), .o_a_rsp(a_rsp), .o_a_rdata(a_rdata),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_wr(b_wr), .i_b_addr(b_addr),
    .i_b_wdata(b_wdata), .o_b_rsp(b_rsp), .o_b_rdata(b_rdata),
    .o_wr_en(wr_en), .o_waddr(waddr), .o_wdata(wdata),
    .o_rd_en(rd_en), .o_raddr(raddr), .i_rdata(rdata_q)
  );

  // BRAM model: read-before-write on a same-address collision, 1-cycle read.
  always @(posedge clk) begin
    if (wr_en) mem[waddr] <= wdata;
    if (rd_en) rdata_q <= mem[raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b1; a_wr = 1'b0; a_addr = 8'h00; a_wdata = 16'h0;
    b_valid = 1'b1; b_wr = 1'b1; b_addr = 8'h05; b_wdata = 16'h0007;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_wr_en",   wr_en, 0);
    chk("rst_rd_en",   rd_en, 0);
    chk("rst_a_rsp",   a_rsp, 0);
    chk("rst_waddr",   waddr, 0);
    b_valid = 1'b0; b_wr = 1'b0;
    rst_n = 1'b1;

    // Settle: 64 cycles without a grant, then A's read goes through.
    for (int k = 0; k < 64; k++) begin
      #1;
      chk("settle_hold", {a_ready, rd_en}, 0);
      cyc();
    end
    #1;
    chk("settle_grant", a_ready, 1);
    chk("settle_rd_en", rd_en, 1);
    cyc(); a_valid = 1'b0; #1;
    chk("settle_rsp", a_rsp, 1);
    chk("settle_b_rsp", b_rsp, 0);

    // Basic write then read of FF.
    cyc(); a_valid = 1'b1; a_wr = 1'b1; a_addr = 8'hFF; a_wdata = 16'hBE11; #1;
    chk("basic_wr_ready", a_ready, 1);
    chk("basic_wr_en", wr_en, 1);
    chk("basic_waddr", waddr, 8'hFF);
    chk("basic_wdata", wdata, 16'hBE11);
    chk("basic_wr_no_rd", rd_en, 0);
    cyc(); a_wr = 1'b0; #1;
    chk("basic_rd_ready", a_ready, 1);
    chk("basic_raddr", raddr, 8'hFF);
    cyc(); a_valid = 1'b0; #1;
    chk("basic_a_rsp", a_rsp, 1);
    chk("basic_a_rdata", a_rdata, 16'hBE11);
    chk("basic_b_rsp", b_rsp, 0);
    cyc(); #1;
    chk("basic_rsp_drop", a_rsp, 0);
    chk("basic_rdata_zero", a_rdata, 0);

    // B writes 10<-1234 then reads it back (read pointer now points at B).
    cyc(); b_valid = 1'b1; b_wr = 1'b1; b_addr = 8'h10; b_wdata = 16'h1234; #1;
    chk("bwr_ready", b_ready, 1);
    chk("bwr_waddr", waddr, 8'h10);
    cyc(); b_wr = 1'b0; #1;
    chk("brd_ready", b_ready, 1);
    chk("brd_raddr", raddr, 8'h10);

    // Read contention: grants A,B,A,B with responses one cycle behind.
    cyc(); a_valid = 1'b1; a_wr = 1'b0; a_addr = 8'hFF; #1;
    chk("cont1_a_ready", a_ready, 1);
    chk("cont1_b_ready", b_ready, 0);
    chk("cont1_b_rsp", b_rsp, 1);
    chk("cont1_b_rdata", b_rdata, 16'h1234);
    cyc(); #1;
    chk("cont2_a_ready", a_ready, 0);
    chk("cont2_b_ready", b_ready, 1);
    chk("cont2_raddr", raddr, 8'h10);
    chk("cont2_a_rsp", a_rsp, 1);
    chk("cont2_a_rdata", a_rdata, 16'hBE11);
    chk("cont2_b_rsp", b_rsp, 0);
    cyc(); #1;
    chk("cont3_a_ready", a_ready, 1);
    chk("cont3_b_ready", b_ready, 0);
    chk("cont3_b_rdata", b_rdata, 16'h1234);
    chk("cont3_a_rsp", a_rsp, 0);
    cyc(); #1;
    chk("cont4_a_ready", a_ready, 0);
    chk("cont4_b_ready", b_ready, 1);
    chk("cont4_a_rdata", a_rdata, 16'hBE11);
    cyc(); a_valid = 1'b0; b_valid = 1'b0; #1;
    chk("cont5_b_rsp", b_rsp, 1);
    chk("cont5_b_rdata", b_rdata, 16'h1234);
    chk("cont5_a_rsp", a_rsp, 0);

    // Split port: A writes 95 while B reads FF.
    cyc(); a_valid = 1'b1; a_wr = 1'b1; a_addr = 8'h95; a_wdata = 16'hC0DE;
    b_valid = 1'b1; b_wr = 1'b0; b_addr = 8'hFF; #1;
    chk("split_a_ready", a_ready, 1);
    chk("split_b_ready", b_ready, 1);
    chk("split_waddr", waddr, 8'h95);
    chk("split_raddr", raddr, 8'hFF);
    // Bypass: A writes FF<-DEAD while B reads FF.
    cyc(); a_addr = 8'hFF; a_wdata = 16'hDEAD; #1;
    chk("split_b_rsp", b_rsp, 1);
    chk("split_b_rdata", b_rdata, 16'hBE11);
    chk("split_a_rsp", a_rsp, 0);
    chk("byp_a_ready", a_ready, 1);
    chk("byp_b_ready", b_ready, 1);
    cyc(); a_valid = 1'b0; b_valid = 1'b0; #1;
    chk("byp_b_rsp", b_rsp, 1);
    chk("byp_b_rdata", b_rdata, 16'hDEAD);
    cyc(); b_valid = 1'b1; #1;
    chk("reread_ready", b_ready, 1);
    cyc(); b_valid = 1'b0; #1;
    chk("reread_b_rdata", b_rdata, 16'hDEAD);

    // Write contention: A wrote last, so B wins the tie.
    cyc(); a_valid = 1'b1; a_wr = 1'b1; a_addr = 8'h20; a_wdata = 16'h1111;
    b_valid = 1'b1; b_wr = 1'b1; b_addr = 8'h21; b_wdata = 16'h2222; #1;
    chk("wcont_b_ready", b_ready, 1);
    chk("wcont_a_ready", a_ready, 0);
    chk("wcont_waddr", waddr, 8'h21);
    chk("wcont_wdata", wdata, 16'h2222);
    cyc(); b_valid = 1'b0; #1;
    chk("wcont_a_next", a_ready, 1);
    chk("wcont_waddr2", waddr, 8'h20);

    // Mid-op reset: A read granted, reset asserted before the capturing edge.
    cyc(); a_wr = 1'b0; a_addr = 8'h95; #1;
    chk("mid_a_ready", a_ready, 1);
    #1; rst_n = 1'b0;
    cyc(); #1;
    chk("mid_a_rsp", a_rsp, 0);
    chk("mid_a_rdata", a_rdata, 0);
    chk("mid_a_ready_rst", a_ready, 0);
    chk("mid_rd_en", rd_en, 0);
    chk("mid_raddr", raddr, 0);
    cyc(); rst_n = 1'b1;
    for (int k = 0; k < 64; k++) begin
      #1;
      chk("resettle_hold", {a_ready, a_rsp}, 0);
      cyc();
    end
    #1;
    chk("resettle_grant", a_ready, 1);
    cyc(); a_valid = 1'b0; #1;
    chk("resettle_rsp", a_rsp, 1);
    chk("resettle_rdata", a_rdata, 16'hC0DE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
